// File: rtl/cnu_deg6.sv
// Degree-6 min-sum check node unit: six signed Q messages in, six extrinsic R messages out.
// One-cycle latency with registered outputs and asynchronous active-low reset.
module cnu_deg6 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Q1,
    input  logic [WIDTH-1:0] Q2,
    input  logic [WIDTH-1:0] Q3,
    input  logic [WIDTH-1:0] Q4,
    input  logic [WIDTH-1:0] Q5,
    input  logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] R3,
    output logic [WIDTH-1:0] R4,
    output logic [WIDTH-1:0] R5,
    output logic [WIDTH-1:0] R6
);

    localparam int unsigned N    = 6;
    localparam int unsigned IDXW = 3;
    localparam logic [WIDTH-1:0] MAX_MAG = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q      [N];
    logic [WIDTH-1:0] mag    [N];
    logic [WIDTH-1:0] r_next [N];
    logic [WIDTH-1:0] r      [N];
    logic [N-1:0]     sgn;
    logic             sgn_all;
    logic [WIDTH-1:0] min1;
    logic [WIDTH-1:0] min2;
    logic [IDXW-1:0]  idx;

    assign q[0] = Q1;
    assign q[1] = Q2;
    assign q[2] = Q3;
    assign q[3] = Q4;
    assign q[4] = Q5;
    assign q[5] = Q6;

    // Sign/magnitude split; the most negative value saturates so later negation is safe.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            sgn[i] = q[i][WIDTH-1];
            if (q[i] == MOST_NEG) begin
                mag[i] = MAX_MAG;
            end else if (q[i][WIDTH-1]) begin
                mag[i] = WIDTH'(-q[i]);
            end else begin
                mag[i] = q[i];
            end
        end
    end

    assign sgn_all = ^sgn;

    // Smallest magnitude; strict compare keeps the lowest index on ties.
    always_comb begin
        min1 = mag[0];
        idx  = '0;
        for (int i = 1; i < N; i++) begin
            if (mag[i] < min1) begin
                min1 = mag[i];
                idx  = IDXW'(i);
            end
        end
    end

    // Second smallest excludes only the winning position, so a tie yields min2 == min1.
    always_comb begin
        min2 = MAX_MAG;
        for (int i = 0; i < N; i++) begin
            if ((IDXW'(i) != idx) && (mag[i] < min2)) begin
                min2 = mag[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (sgn_all ^ sgn[i]) begin
                r_next[i] = (IDXW'(i) == idx) ? WIDTH'(-min2) : WIDTH'(-min1);
            end else begin
                r_next[i] = (IDXW'(i) == idx) ? min2 : min1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r[i] <= r_next[i];
            end
        end
    end

    assign R1 = r[0];
    assign R2 = r[1];
    assign R3 = r[2];
    assign R4 = r[3];
    assign R5 = r[4];
    assign R6 = r[5];

endmodule

// File: tb/tb_cnu_deg6.sv
// Self-checking bench for cnu_deg6: directed vectors plus randomized traffic checked
// against a direct extrinsic min-sum model computed with plain integer arithmetic.
module tb_cnu_deg6;

    logic        clk;
    logic        rst;
    logic [31:0] q_tb [6];
    logic [31:0] r_obs [6];
    logic [31:0] exp_r [6];
    int          checks;
    int          errors;

    cnu_deg6 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .Q1  (q_tb[0]),
        .Q2  (q_tb[1]),
        .Q3  (q_tb[2]),
        .Q4  (q_tb[3]),
        .Q5  (q_tb[4]),
        .Q6  (q_tb[5]),
        .R1  (r_obs[0]),
        .R2  (r_obs[1]),
        .R3  (r_obs[2]),
        .R4  (r_obs[3]),
        .R5  (r_obs[4]),
        .R6  (r_obs[5])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R_i = (product of the other five signs) * (smallest other saturated magnitude).
    function automatic logic [31:0] model_r(input logic [31:0] qv [6], input int i);
        longint best;
        longint m;
        longint v;
        bit     neg;
        best = 64'sd2147483647;
        neg  = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j != i) begin
                v = longint'($signed(qv[j]));
                m = (v < 0) ? -v : v;
                if (m > 64'sd2147483647) m = 64'sd2147483647;
                if (m < best) best = m;
                if (v < 0) neg = ~neg;
            end
        end
        return neg ? 32'(-best) : 32'(best);
    endfunction

    task automatic compute_expected();
        for (int i = 0; i < 6; i++) exp_r[i] = model_r(q_tb, i);
    endtask

    task automatic compare_all(input string name, input logic [31:0] want [6]);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (r_obs[i] !== want[i]) begin
                errors++;
                $display("FAIL %s R%0d got %h expected %h", name, i + 1, r_obs[i], want[i]);
            end
        end
    endtask

    function automatic logic [31:0] rand_q();
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0001;
            3, 4, 5: return 32'($signed($urandom_range(0, 16)) - 8);
            default: return $urandom();
        endcase
    endfunction

    task automatic set_q(input logic [31:0] a, b, c, d, e, f);
        q_tb[0] = a; q_tb[1] = b; q_tb[2] = c;
        q_tb[3] = d; q_tb[4] = e; q_tb[5] = f;
    endtask

    task automatic test_reset();
        logic [31:0] zeros [6];
        for (int i = 0; i < 6; i++) zeros[i] = 32'h0;
        @(negedge clk);
        set_q(32'd5, 32'hFFFF_FFF0, 32'd9, 32'd1, 32'd77, 32'h8000_0000);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 compare_all("reset_async", zeros);
        @(negedge clk);
        @(negedge clk);
        compare_all("reset_held", zeros);
        rst = 1'b1;
        #1 compare_all("reset_release_no_edge", zeros);
    endtask

    task automatic run_directed(input string name, input logic [31:0] want [6]);
        @(negedge clk);
        compare_all(name, want);
        compute_expected();
        compare_all({name, "_model"}, exp_r);
    endtask

    task automatic test_directed();
        logic [31:0] w [6];
        @(negedge clk);
        set_q(-32'sd2, -32'sd4, 32'd5, -32'sd6, 32'd7, 32'd8);
        w[0] = 32'd4; w[1] = 32'd2; w[2] = -32'sd2; w[3] = 32'd2; w[4] = -32'sd2; w[5] = -32'sd2;
        run_directed("mixed_signs", w);

        set_q(32'd3, 32'd9, 32'd1, 32'd6, 32'd1, 32'd4);
        for (int i = 0; i < 6; i++) w[i] = 32'd1;
        run_directed("all_positive_tie", w);

        set_q(32'd0, -32'sd5, 32'd7, -32'sd3, 32'd2, 32'd9);
        w[0] = 32'd2;
        for (int i = 1; i < 6; i++) w[i] = 32'd0;
        run_directed("zero_input", w);

        set_q(32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        w[0] = 32'h7FFF_FFFF;
        for (int i = 1; i < 6; i++) w[i] = 32'h8000_0001;
        run_directed("saturation", w);

        // Held input must keep R stable over further edges.
        @(negedge clk);
        compare_all("saturation_hold", w);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 6; i++) q_tb[i] = rand_q();
            compute_expected();
            @(negedge clk);
            compare_all("random", exp_r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev [6];
        @(negedge clk);
        for (int i = 0; i < 6; i++) q_tb[i] = rand_q();
        compute_expected();
        prev = exp_r;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            compare_all("back_to_back", prev);
            for (int i = 0; i < 6; i++) q_tb[i] = rand_q();
            compute_expected();
            prev = exp_r;
            if (n == 20) begin
                logic [31:0] zeros [6];
                for (int i = 0; i < 6; i++) zeros[i] = 32'h0;
                #1 rst = 1'b0;
                #1 compare_all("midstream_reset", zeros);
                @(negedge clk);
                compare_all("midstream_reset_held", zeros);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        compare_all("back_to_back_last", prev);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) q_tb[i] = 32'h0;
        #2;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
